// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor; ovf exists only with SERIAL_SUB_OVF_EN.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

`ifdef SERIAL_SUB_OVF_EN
  modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
`else
  modport master (output start, a, b, bin, input busy, done, diff, bout);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, one full-subtractor bit per clock, LSB first.
// Optional SERIAL_SUB_OVF_EN adds a signed-overflow flag (ovf).
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  serial_subtractor_if.slave bus
);
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic fs_diff(input logic x, input logic y, input logic cin);
    return x ^ y ^ cin;
  endfunction

  function automatic logic fs_borrow(input logic x, input logic y, input logic cin);
    return (~x & y) | (~(x ^ y) & cin);
  endfunction

  state_t           state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] res_r;
  logic             borrow_r;
  logic [CNT_W-1:0] count_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_r;
`endif

  logic             d_s;
  logic             borrow_nx_s;
  logic [WIDTH-1:0] res_nx_s;
  logic             last_s;

  // Full-subtractor cell on the current LSBs and next-state result image
  always_comb begin
    d_s         = fs_diff(a_sh_r[0], b_sh_r[0], borrow_r);
    borrow_nx_s = fs_borrow(a_sh_r[0], b_sh_r[0], borrow_r);
    res_nx_s    = {d_s, res_r[WIDTH-1:1]};
    if (count_r == CNT_W'(WIDTH - 1)) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
  end

  // Control FSM, datapath shifting and registered result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      res_r    <= {WIDTH{1'b0}};
      borrow_r <= 1'b0;
      count_r  <= {CNT_W{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      diff_r   <= {WIDTH{1'b0}};
      bout_r   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_r    <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_sh_r   <= bus.a;
            b_sh_r   <= bus.b;
            borrow_r <= bus.bin;
            count_r  <= {CNT_W{1'b0}};
            busy_r   <= 1'b1;
            state_r  <= SHIFT;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          res_r    <= res_nx_s;
          borrow_r <= borrow_nx_s;
          if (last_s) begin
            count_r <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            diff_r  <= res_nx_s;
            bout_r  <= borrow_nx_s;
`ifdef SERIAL_SUB_OVF_EN
            // borrow_r here is the borrow into the MSB cell
            ovf_r   <= borrow_r ^ borrow_nx_s;
`endif
            state_r <= DONE;
          end else begin
            count_r <= count_r + CNT_W'(1);
            state_r <= SHIFT;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.diff = diff_r;
  assign bus.bout = bout_r;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf  = ovf_r;
`endif

endmodule
